// File: rtl/axi_rd_burst_mem_if.sv
// AXI read-address and read-data channels shared by the burst memory and its master.
// The master drives the AR request and rready; the slave drives arready and the R beat.
interface axi_rd_burst_mem_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 4
);
   logic [ID_WIDTH-1:0]   arid;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [7:0]            arlen;
   logic [1:0]            arburst;
   logic                  arvalid;
   logic                  arready;
   logic [ID_WIDTH-1:0]   rid;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rlast;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output arid, araddr, arlen, arburst, arvalid, rready,
      input  arready, rid, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  arid, araddr, arlen, arburst, arvalid, rready,
      output arready, rid, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/axi_rd_burst_mem.sv
// Single-outstanding AXI read-burst memory with FIXED/INCR/WRAP addressing and a side preload port.
// Out-of-range words and illegal burst shapes answer SLVERR with zero data, keeping the beat count.
module axi_rd_burst_mem #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int DEPTH      = 1024
) (
   input  logic                     aclk,
   input  logic                     areset,
   axi_rd_burst_mem_if.slave        bus,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0]    wr_data
);
   localparam int OFFS_W = $clog2(DATA_WIDTH / 8);
   localparam int IDX_W  = ADDR_WIDTH - OFFS_W;
   localparam int MEM_AW = $clog2(DEPTH);

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {S_IDLE, S_BURST} state_t;

   state_t                r_state;
   logic                  r_arready;
   logic [ID_WIDTH-1:0]   r_id;
   logic [7:0]            r_len;
   logic [1:0]            r_burst;
   logic                  r_err;
   logic [IDX_W-1:0]      r_idx;
   logic [7:0]            r_beat;
   logic                  r_rvalid;
   logic                  r_rlast;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [1:0]            r_rresp;

   // NOTE: the preload memory is deliberately left out of the reset so it maps onto plain RAM.
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic [IDX_W-1:0]      w_req_idx;
   logic                  w_wrap_len_ok;
   logic                  w_req_err;
   logic [IDX_W-1:0]      w_wrap_mask;
   logic [IDX_W-1:0]      w_next_idx;
   logic [IDX_W-1:0]      w_fetch_idx;
   logic                  w_fetch_err;
   logic [DATA_WIDTH-1:0] w_mem_q;
   logic [DATA_WIDTH-1:0] w_beat_data;
   logic [1:0]            w_beat_resp;
   logic                  w_ar_hs;
   logic                  w_r_hs;
   logic                  w_unused;

   // Byte-offset bits never select data: every beat is a full word.
   assign w_unused  = ^bus.araddr[OFFS_W-1:0];
   assign w_req_idx = bus.araddr[ADDR_WIDTH-1:OFFS_W];

   assign w_wrap_len_ok = (bus.arlen == 8'd1) || (bus.arlen == 8'd3) ||
                          (bus.arlen == 8'd7) || (bus.arlen == 8'd15);
   assign w_req_err     = (bus.arburst == 2'b11) ||
                          ((bus.arburst == BURST_WRAP) && !w_wrap_len_ok);

   assign w_wrap_mask = {{(IDX_W-8){1'b0}}, r_len};

   // NOTE: every path assigns w_next_idx after the leading default, so no latch is inferred.
   always_comb begin
      w_next_idx = r_idx;
      case (r_burst)
         BURST_FIXED: w_next_idx = r_idx;
         BURST_INCR:  w_next_idx = r_idx + 1'b1;
         BURST_WRAP:  w_next_idx = (r_idx & ~w_wrap_mask) | ((r_idx + 1'b1) & w_wrap_mask);
         default:     w_next_idx = r_idx;
      endcase
   end

   // The beat being fetched is beat 0 on the AR handshake, otherwise the successor of r_idx.
   assign w_fetch_idx = (r_state == S_IDLE) ? w_req_idx : w_next_idx;
   assign w_fetch_err = ((r_state == S_IDLE) ? w_req_err : r_err) |
                        (|w_fetch_idx[IDX_W-1:MEM_AW]);
   assign w_mem_q     = r_mem[w_fetch_idx[MEM_AW-1:0]];
   assign w_beat_data = w_fetch_err ? '0 : w_mem_q;
   assign w_beat_resp = w_fetch_err ? RESP_SLVERR : RESP_OKAY;

   assign w_ar_hs = bus.arvalid & r_arready;
   assign w_r_hs  = r_rvalid & bus.rready;

   always_ff @(posedge aclk) begin
      if (wr_en) r_mem[wr_addr] <= wr_data;
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values;
   // this is also why a same-edge preload write leaves the fetched beat with the old word.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state   <= S_IDLE;
         r_arready <= 1'b0;
         r_id      <= '0;
         r_len     <= '0;
         r_burst   <= BURST_FIXED;
         r_err     <= 1'b0;
         r_idx     <= '0;
         r_beat    <= '0;
         r_rvalid  <= 1'b0;
         r_rlast   <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= RESP_OKAY;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_arready <= 1'b1;
               if (w_ar_hs) begin
                  r_id      <= bus.arid;
                  r_len     <= bus.arlen;
                  r_burst   <= bus.arburst;
                  r_err     <= w_req_err;
                  r_idx     <= w_req_idx;
                  r_beat    <= '0;
                  r_rvalid  <= 1'b1;
                  r_rlast   <= (bus.arlen == 8'd0);
                  r_rdata   <= w_beat_data;
                  r_rresp   <= w_beat_resp;
                  r_arready <= 1'b0;
                  r_state   <= S_BURST;
               end
            end
            S_BURST: begin
               if (w_r_hs) begin
                  if (r_rlast) begin
                     r_rvalid  <= 1'b0;
                     r_rlast   <= 1'b0;
                     r_arready <= 1'b1;
                     r_state   <= S_IDLE;
                  end else begin
                     r_idx   <= w_next_idx;
                     r_beat  <= r_beat + 8'd1;
                     r_rlast <= ((r_beat + 8'd1) == r_len);
                     r_rdata <= w_beat_data;
                     r_rresp <= w_beat_resp;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.arready = r_arready;
   assign bus.rid     = r_id;
   assign bus.rdata   = r_rdata;
   assign bus.rresp   = r_rresp;
   assign bus.rlast   = r_rlast;
   assign bus.rvalid  = r_rvalid;
endmodule

// File: tb/tb_axi_rd_burst_mem.sv
// Directed bench for axi_rd_burst_mem: stimulus pushes expected beats into a queue,
// an independent negedge monitor pops and compares every accepted beat and checks stall stability.
module tb_axi_rd_burst_mem;
   localparam logic [1:0] FIXED = 2'b00;
   localparam logic [1:0] INCR  = 2'b01;
   localparam logic [1:0] WRAP  = 2'b10;
   localparam logic [1:0] RSVD  = 2'b11;
   localparam logic [1:0] OKAY  = 2'b00;
   localparam logic [1:0] SLV   = 2'b10;

   typedef struct {
      logic [3:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } beat_t;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic [9:0]  wr_addr;
   logic [31:0] wr_data;

   int    checks   = 0;
   int    failures = 0;
   beat_t exp_q[$];

   axi_rd_burst_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4)) bus ();

   axi_rd_burst_mem #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4), .DEPTH(1024)
   ) dut (
      .aclk(clk), .areset(rst), .bus(bus),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic push(input logic [3:0] id, input logic [31:0] data, input logic [1:0] resp,
                       input logic last);
      beat_t b;
      b.id = id; b.data = data; b.resp = resp; b.last = last;
      exp_q.push_back(b);
   endtask

   // Monitor: compares accepted beats against the queue and holds stalled beats to their last value.
   initial begin
      logic        prev_stall;
      logic [38:0] prev_beat;
      logic [38:0] cur_beat;
      beat_t       e;
      prev_stall = 1'b0;
      prev_beat  = '0;
      forever begin
         @(negedge clk);
         cur_beat = {bus.rid, bus.rdata, bus.rresp, bus.rlast};
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) check("stall_hold", {bus.rvalid, cur_beat}, {1'b1, prev_beat});
            if (bus.rvalid && bus.rready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_beat", {25'd0, cur_beat}, 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("beat", {25'd0, cur_beat}, {25'd0, e.id, e.data, e.resp, e.last});
               end
            end
            prev_stall = bus.rvalid && !bus.rready;
            prev_beat  = cur_beat;
         end
      end
   end

   task automatic write_word(input logic [9:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   // Presents an AR request (optionally with a same-edge preload write) and returns #1 after acceptance.
   task automatic ar_handshake(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input bit do_wr, input logic [9:0] wa,
                               input logic [31:0] wd);
      bit ok;
      @(posedge clk); #1;
      bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arburst = burst;
      bus.arvalid = 1'b1; bus.rready = 1'b1;
      if (do_wr) begin
         wr_en = 1'b1; wr_addr = wa; wr_data = wd;
      end
      ok = 1'b0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (bus.arready) begin
            ok = 1'b1;
            break;
         end
      end
      check("ar_accept", {63'd0, ok}, 64'd1);
      @(posedge clk); #1;
      bus.arvalid = 1'b0;
      wr_en = 1'b0;
   endtask

   task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input bit toggle, input int exp_cyc,
                            input bit do_wr, input logic [9:0] wa, input logic [31:0] wd);
      int cyc;
      bit done;
      ar_handshake(id, addr, len, burst, do_wr, wa, wd);
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) check("beat0_next_cycle", {62'd0, bus.rvalid, bus.arready}, 64'b10);
         else if (!done) check("arready_low_in_burst", {63'd0, bus.arready}, 64'd0);
         if (bus.rvalid && bus.rready && bus.rlast) done = 1'b1;
         @(posedge clk); #1;
         if (toggle && !done) bus.rready = ~bus.rready;
      end
      bus.rready = 1'b1;
      check("burst_cycles", 64'(cyc), 64'(exp_cyc));
      @(negedge clk);
      check("idle_after_last", {62'd0, bus.rvalid, bus.arready}, 64'b01);
   endtask

   initial begin
      rst = 1'b1;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arburst = '0;
      bus.arvalid = 1'b0; bus.rready = 1'b0;

      // Preload happens while reset is held: the memory port does not depend on reset.
      for (int k = 0; k < 16; k++) write_word(10'(k), 32'h100 + 32'(k));
      write_word(10'd1022, 32'hBEEF_03FE);
      write_word(10'd1023, 32'hBEEF_03FF);

      @(negedge clk);
      check("reset_outputs",
            {19'd0, bus.rvalid, bus.rlast, bus.rresp, bus.rdata, bus.rid, bus.arready}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("arready_after_reset", {63'd0, bus.arready}, 64'd1);

      // INCR from word 4, id 5, back-to-back beats.
      push(4'd5, 32'h104, OKAY, 1'b0);
      push(4'd5, 32'h105, OKAY, 1'b0);
      push(4'd5, 32'h106, OKAY, 1'b0);
      push(4'd5, 32'h107, OKAY, 1'b1);
      run_burst(4'd5, 32'h10, 8'd3, INCR, 1'b0, 4, 1'b0, '0, '0);

      // WRAP len 4 from word 6: 6,7,4,5.
      push(4'd2, 32'h106, OKAY, 1'b0);
      push(4'd2, 32'h107, OKAY, 1'b0);
      push(4'd2, 32'h104, OKAY, 1'b0);
      push(4'd2, 32'h105, OKAY, 1'b1);
      run_burst(4'd2, 32'h18, 8'd3, WRAP, 1'b0, 4, 1'b0, '0, '0);

      // WRAP with an illegal length: all SLVERR, still 3 beats.
      push(4'd3, 32'h0, SLV, 1'b0);
      push(4'd3, 32'h0, SLV, 1'b0);
      push(4'd3, 32'h0, SLV, 1'b1);
      run_burst(4'd3, 32'h18, 8'd2, WRAP, 1'b0, 3, 1'b0, '0, '0);

      // FIXED word 2 with rready toggling: 5 beats over 9 cycles.
      push(4'd1, 32'h102, OKAY, 1'b0);
      push(4'd1, 32'h102, OKAY, 1'b0);
      push(4'd1, 32'h102, OKAY, 1'b0);
      push(4'd1, 32'h102, OKAY, 1'b0);
      push(4'd1, 32'h102, OKAY, 1'b1);
      run_burst(4'd1, 32'h8, 8'd4, FIXED, 1'b1, 9, 1'b0, '0, '0);

      // INCR running off the end of memory at word 1024.
      push(4'd4, 32'hBEEF_03FE, OKAY, 1'b0);
      push(4'd4, 32'hBEEF_03FF, OKAY, 1'b0);
      push(4'd4, 32'h0, SLV, 1'b0);
      push(4'd4, 32'h0, SLV, 1'b1);
      run_burst(4'd4, 32'hFF8, 8'd3, INCR, 1'b0, 4, 1'b0, '0, '0);

      // Reserved burst type: SLVERR on both beats.
      push(4'd6, 32'h0, SLV, 1'b0);
      push(4'd6, 32'h0, SLV, 1'b1);
      run_burst(4'd6, 32'h4, 8'd1, RSVD, 1'b0, 2, 1'b0, '0, '0);

      // Reset while beat 2 of an 8-beat burst is being presented.
      push(4'd7, 32'h100, OKAY, 1'b0);
      push(4'd7, 32'h101, OKAY, 1'b0);
      ar_handshake(4'd7, 32'h0, 8'd7, INCR, 1'b0, '0, '0);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("reset_abort", {61'd0, bus.rvalid, bus.rlast, bus.arready}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("arready_after_abort", {62'd0, bus.rvalid, bus.arready}, 64'b01);
      push(4'd9, 32'h100, OKAY, 1'b0);
      push(4'd9, 32'h101, OKAY, 1'b1);
      run_burst(4'd9, 32'h0, 8'd1, INCR, 1'b0, 2, 1'b0, '0, '0);

      // Same-edge write to word 6 while it is fetched returns the old word, then the new one.
      push(4'd8, 32'h106, OKAY, 1'b1);
      run_burst(4'd8, 32'h18, 8'd0, INCR, 1'b0, 1, 1'b1, 10'd6, 32'hAAAA);
      push(4'd8, 32'hAAAA, OKAY, 1'b1);
      run_burst(4'd8, 32'h18, 8'd0, FIXED, 1'b0, 1, 1'b0, '0, '0);

      repeat (3) @(posedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
